inst_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of the post-IF/ID register. Owns the PC, issues one-outstanding SRAM-like requests to the instruction bus and delivers `postif_*` results downstream. Also handles branch redirects (delay slot preserved), exception flushes and misaligned-PC (AdEL) faults, and raises the inst-stall request while a fetch is in flight.

---
 rtl/inst_fetch.sv | 191 +++++++++++++++++++
 tb/tb_inst_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS instruction-fetch stage feeding the post-IF/ID register.
// Owns the PC and issues one request at a time to an SRAM-like instruction bus.
// The fetched word is held in registered postif_* outputs until downstream accepts it.
// Branch redirects are latched and take effect after the delay-slot fetch is delivered.
// Exceptions discard the fetch in flight and restart at the handler address.
// A misaligned PC never reaches the bus; it is reported as an AdEL fault.
//
// Ports:
//   clock_i, reset_i          clock (rising edge), async active-low reset
//   stall_i[3:0]              {data, exe, id, inst} stalls; [3:1] hold the OUT state
//   branch_enable_i/target_i  one-cycle redirect from ID
//   exception_i/pc_i          one-cycle flush with handler address
//   inst_req_o/addr_o         bus request and address
//   inst_addr_ok_i            bus accepted the address
//   inst_data_ok_i/rdata_i    bus returned data
//   postif_pc/inst/exception_type_o  delivered instruction
//   postif_inst_ren_o         address handshake this cycle
//   postif_inst_ok_o          accepted (non-discarded) data this cycle
//   postif_inst_valid_o       delivered result valid
//   inst_stall_req_o          fetch not yet delivered
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          ADEL_BIT = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  stall_i,
  input  logic        branch_enable_i,
  input  logic [31:0] branch_target_i,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] postif_pc_o,
  output logic [31:0] postif_inst_o,
  output logic [31:0] postif_exception_type_o,
  output logic        postif_inst_ren_o,
  output logic        postif_inst_ok_o,
  output logic        postif_inst_valid_o,
  output logic        inst_stall_req_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        ex_pend_q, ex_pend_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_exc_q, out_exc_d;
  logic        valid_q, valid_d;
  logic        stall_req_q, stall_req_d;

  logic        misaligned, ds_stall, ex_any, drop_data, br_any;
  logic [31:0] ex_target, br_target;
  logic        unused_stall0;

  // This stage's own stall request loops back on stall_i[0]; only the
  // downstream stalls can hold a delivered result.
  assign unused_stall0 = stall_i[0];

  assign misaligned = |pc_q[1:0];
  assign ds_stall   = |stall_i[3:1];
  assign ex_any     = exception_i | ex_pend_q;
  assign ex_target  = exception_i ? exception_pc_i : ex_pc_q;
  assign br_any     = branch_enable_i | br_pend_q;
  assign br_target  = branch_enable_i ? branch_target_i : br_tgt_q;
  // Data returning in WAIT is thrown away if a flush hit this fetch,
  // including a flush arriving in the same cycle as the data.
  assign drop_data  = discard_q | exception_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= '0;
      ex_pend_q   <= 1'b0;
      ex_pc_q     <= '0;
      discard_q   <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_exc_q   <= '0;
      valid_q     <= 1'b0;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      br_pend_q   <= br_pend_d;
      br_tgt_q    <= br_tgt_d;
      ex_pend_q   <= ex_pend_d;
      ex_pc_q     <= ex_pc_d;
      discard_q   <= discard_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_exc_q   <= out_exc_d;
      valid_q     <= valid_d;
      stall_req_q <= stall_req_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // A misaligned PC never goes to the bus; a flush redirects it in place.
        if (misaligned)          state_d = ex_any ? S_REQ : S_OUT;
        else if (inst_addr_ok_i) state_d = S_WAIT;
      end
      S_WAIT: if (inst_data_ok_i) state_d = drop_data ? S_REQ : S_OUT;
      S_OUT:  if (ex_any || !ds_stall) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath
    pc_d       = pc_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    ex_pend_d  = ex_pend_q;
    ex_pc_d    = ex_pc_q;
    discard_d  = discard_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    out_exc_d  = out_exc_q;

    // Capture redirects; an exception wins over a simultaneous branch and
    // cancels any branch still waiting.
    if (exception_i) begin
      ex_pend_d = 1'b1;
      ex_pc_d   = exception_pc_i;
      br_pend_d = 1'b0;
    end else if (branch_enable_i) begin
      br_pend_d = 1'b1;
      br_tgt_d  = branch_target_i;
    end

    // Mark the outstanding transaction for discard once a flush touches it.
    if ((state_q == S_REQ && !misaligned && inst_addr_ok_i && ex_any) ||
        (state_q == S_WAIT && !inst_data_ok_i && exception_i))
      discard_d = 1'b1;

    // Flush redirect: restart at the handler and forget everything pending.
    if ((state_q == S_REQ && misaligned && ex_any) ||
        (state_q == S_WAIT && inst_data_ok_i && drop_data) ||
        (state_q == S_OUT && ex_any)) begin
      pc_d      = ex_target;
      ex_pend_d = 1'b0;
      br_pend_d = 1'b0;
      discard_d = 1'b0;
    end else if (state_q == S_OUT && !ds_stall) begin
      pc_d      = br_any ? br_target : pc_q + 32'd4;
      br_pend_d = 1'b0;
    end

    // postif_* are loaded only on entry into OUT.
    if (state_q == S_WAIT && inst_data_ok_i && !drop_data) begin
      out_pc_d   = pc_q;
      out_inst_d = inst_rdata_i;
      out_exc_d  = '0;
    end else if (state_q == S_REQ && misaligned && !ex_any) begin
      out_pc_d   = pc_q;
      out_inst_d = '0;
      out_exc_d  = 32'd1 << ADEL_BIT;
    end
  end

  always_comb begin : outputs
    valid_d           = (state_d == S_OUT);
    stall_req_d       = (state_d != S_OUT);
    inst_req_o        = (state_q == S_REQ) && !misaligned;
    inst_addr_o       = inst_req_o ? pc_q : 32'd0;
    postif_inst_ren_o = inst_req_o && inst_addr_ok_i;
    postif_inst_ok_o  = (state_q == S_WAIT) && inst_data_ok_i && !drop_data;
  end

  assign postif_pc_o             = out_pc_q;
  assign postif_inst_o           = out_inst_q;
  assign postif_exception_type_o = out_exc_q;
  assign postif_inst_valid_o     = valid_q;
  assign inst_stall_req_o        = stall_req_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:1]  ds;
  logic        br_en, ex, addr_ok, data_ok;
  logic [31:0] br_tgt, ex_pc, rdata;
  logic        req, ren, ok, valid, stall_req;
  logic [31:0] addr, o_pc, o_inst, o_exc;
  logic [3:0]  stall_vec;

  assign stall_vec = {ds, stall_req};

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .ADEL_BIT(4)) dut (
    .clock_i(clk), .reset_i(rst_n), .stall_i(stall_vec),
    .branch_enable_i(br_en), .branch_target_i(br_tgt),
    .exception_i(ex), .exception_pc_i(ex_pc),
    .inst_req_o(req), .inst_addr_o(addr),
    .inst_addr_ok_i(addr_ok), .inst_data_ok_i(data_ok), .inst_rdata_i(rdata),
    .postif_pc_o(o_pc), .postif_inst_o(o_inst), .postif_exception_type_o(o_exc),
    .postif_inst_ren_o(ren), .postif_inst_ok_o(ok),
    .postif_inst_valid_o(valid), .inst_stall_req_o(stall_req)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;

  // Instruction memory contents seen by the bus model.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    br_en = 1'b0; ex = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
  endtask

  // Monitor: pops an expectation on each new valid result and checks it is
  // held unchanged for as long as valid stays high.
  exp_t mon_cur;
  logic mon_vprev = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    e = mon_cur;
    if (rst_n && valid) begin
      if (!mon_vprev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pc %h, required no delivery", o_pc);
          e = '0;
        end else begin
          e = exp_q.pop_front();
        end
      end
      chk("out_pc", o_pc, e.pc);
      chk("out_inst", o_inst, e.inst);
      chk("out_exc", o_exc, e.exc);
      chk("no_req_in_out", 32'(req), 32'd0);
      chk("stall_req_out", 32'(stall_req), 32'd0);
    end
    if (rst_n && req) chk("stall_req_req", 32'(stall_req), 32'd1);
    mon_cur    <= e;
    mon_vprev  <= rst_n & valid;
  end

  // One fetch. ev: 0 none, 1 branch in REQ, 2 branch in WAIT, 3 two branches
  // (second wins), 4 exception in REQ, 5 exception in WAIT, 6 exception with
  // data_ok, 7 exception+branch together. A misaligned PC is recovered with
  // a branch issued while its fault result is held.
  task automatic fetch(input int ev_in, input logic [31:0] tgt, input logic [31:0] tgt2,
                       input int a_in, input int d_in, input int s, input logic [3:1] st);
    int          ev, a, d, n;
    logic        killed, mis;
    logic [31:0] nxt;
    exp_t        e;
    mis = (m_pc[1:0] != 2'b00);
    ev  = mis ? 8 : ev_in;
    a   = a_in;
    d   = d_in;
    if ((ev == 1 || ev == 3 || ev == 4) && a < 1) a = 1;
    if (ev == 5 && d < 2) d = 2;
    killed = (ev >= 4 && ev <= 7);
    case (ev)
      0:       nxt = m_pc + 32'd4;
      3:       nxt = tgt2;
      8:       nxt = {tgt[31:2], 2'b00};
      default: nxt = tgt;
    endcase
    if (!killed) begin
      e.pc   = m_pc;
      e.inst = mis ? 32'd0 : mem(m_pc);
      e.exc  = mis ? 32'h0000_0010 : 32'd0;
      exp_q.push_back(e);
    end
    if (mis) begin
      n = 0;
      while (!valid && n < 10) begin
        chk("no_req_misaligned", 32'(req), 32'd0);
        tick();
        n++;
      end
      chk("misaligned_valid", 32'(valid), 32'd1);
      ds = 3'b001; br_en = 1'b1; br_tgt = nxt;
      tick();
      br_en = 1'b0;
      for (int i = 0; i < s; i++) begin ds = st; tick(); end
      ds = 3'b000;
      tick();
    end else begin
      n = 0;
      while (!req && n < 20) begin tick(); n++; end
      chk("req_seen", 32'(req), 32'd1);
      chk("req_addr", addr, m_pc);
      for (int i = 0; i < a; i++) begin
        if (i == 0 && (ev == 1 || ev == 3)) begin br_en = 1'b1; br_tgt = tgt; end
        if (i == 0 && ev == 4) begin ex = 1'b1; ex_pc = tgt; end
        tick();
        clear_pulses();
        chk("req_hold", 32'(req), 32'd1);
        chk("addr_hold", addr, m_pc);
      end
      addr_ok = 1'b1;
      #1 chk("ren_pulse", 32'(ren), 32'd1);
      tick();
      addr_ok = 1'b0;
      for (int i = 1; i <= d; i++) begin
        if (i == 1 && ev == 2) begin br_en = 1'b1; br_tgt = tgt; end
        if (i == 1 && ev == 3) begin br_en = 1'b1; br_tgt = tgt2; end
        if (i == 1 && ev == 5) begin ex = 1'b1; ex_pc = tgt; end
        if (i == 1 && ev == 7) begin ex = 1'b1; ex_pc = tgt; br_en = 1'b1; br_tgt = tgt2; end
        if (i == d) begin
          data_ok = 1'b1;
          rdata   = mem(m_pc);
          if (ev == 6) begin ex = 1'b1; ex_pc = tgt; end
        end
        #1;
        if (i == d) chk("ok_pulse", 32'(ok), 32'(!killed));
        tick();
        clear_pulses();
      end
      chk("valid_latency", 32'(valid), 32'(!killed));
      if (!killed) begin
        for (int i = 0; i < s; i++) begin ds = st; tick(); end
        ds = 3'b000;
        tick();
      end
    end
    m_pc = nxt;
  endtask

  initial begin
    rst_n = 1'b0; ds = 3'b000; br_tgt = '0; ex_pc = '0; rdata = '0;
    clear_pulses();
    m_pc = RESET_PC;
    tick(); tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_exc", o_exc, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_ok", 32'(ok), 32'd0);
    rst_n = 1'b1;

    fetch(0, 32'h0, 32'h0, 0, 1, 0, 3'b000);                   // BFC00000
    fetch(0, 32'h0, 32'h0, 0, 1, 0, 3'b000);                   // BFC00004
    fetch(2, 32'hBFC0_0100, 32'h0, 0, 1, 0, 3'b000);           // BFC00008, delay slot
    fetch(5, 32'hBFC0_0380, 32'h0, 0, 2, 0, 3'b000);           // BFC00100 flushed
    fetch(1, 32'hBFC0_0102, 32'h0, 1, 1, 0, 3'b000);           // BFC00380
    fetch(0, 32'hBFC0_0200, 32'h0, 0, 1, 1, 3'b010);           // BFC00102 AdEL
    fetch(0, 32'h0, 32'h0, 0, 1, 5, 3'b010);                   // BFC00200 stalled 5
    fetch(2, 32'hFFFF_FFFC, 32'h0, 0, 1, 0, 3'b000);           // BFC00204
    fetch(0, 32'h0, 32'h0, 0, 1, 0, 3'b000);                   // FFFFFFFC wraps
    fetch(3, 32'hBFC0_0400, 32'hBFC0_0500, 1, 2, 0, 3'b000);   // 00000000
    fetch(6, 32'hBFC0_0380, 32'h0, 0, 1, 0, 3'b000);           // BFC00500 flushed
    fetch(7, 32'hBFC0_0600, 32'hBFC0_0700, 0, 2, 0, 3'b000);   // BFC00380 flushed
    fetch(4, 32'hBFC0_0800, 32'h0, 2, 1, 0, 3'b000);           // BFC00600 flushed

    for (int k = 0; k < 60; k++) begin
      int          ev;
      logic [31:0] t, t2;
      ev = int'($urandom_range(0, 7));
      t  = {16'hBFC0, 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC};
      t2 = {16'hBFC0, 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC};
      if (ev >= 1 && ev <= 3 && $urandom_range(0, 4) == 0) begin
        t[1] = 1'b1; t2[1] = 1'b1;
      end
      fetch(ev, t, t2, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
            int'($urandom_range(0, 3)), 3'($urandom_range(1, 7)));
    end

    // Reset while a response is outstanding, then a stray data_ok.
    begin
      int n;
      n = 0;
      while (!req && n < 20) begin tick(); n++; end
      chk("mid_req_seen", 32'(req), 32'd1);
      addr_ok = 1'b1;
      tick();
      addr_ok = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 32'(req), 32'd0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_pc", o_pc, 32'd0);
      chk("mid_rst_stall", 32'(stall_req), 32'd0);
      tick();
      rst_n = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      #1 chk("stray_ok_idle", 32'(ok), 32'd0);
      tick();
      #1;
      chk("stray_ok_req", 32'(ok), 32'd0);
      chk("restart_req", 32'(req), 32'd1);
      chk("restart_addr", addr, RESET_PC);
      tick();
      data_ok = 1'b0;
      m_pc = RESET_PC;
    end
    fetch(0, 32'h0, 32'h0, 0, 1, 0, 3'b000);
    fetch(0, 32'h0, 32'h0, 1, 2, 1, 3'b100);
    fetch(0, 32'h0, 32'h0, 0, 1, 0, 3'b000);

    tick();
    #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
